// File: rtl/phy_tx_multilane_pkg.sv
// Shared definitions for the multilane PHY transmitter.
//   - default comma (COM) and idle (IDL) symbols
//   - FSM state encoding (ST_SYNC, ST_ACTIVE)
//   - frame content selector used by the striping mux
package phy_tx_multilane_pkg;

    localparam logic [7:0] COM_SYM = 8'hBC;
    localparam logic [7:0] IDL_SYM = 8'h7C;

    typedef enum logic {
        ST_SYNC   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SEL_COM  = 2'd0,
        SEL_IDL  = 2'd1,
        SEL_DATA = 2'd2
    } frame_sel_t;

    // Byte k of a word travels on lane k%LANES in slot k/LANES.
    function automatic int byte_index(input int slot, input int lane, input int lanes);
        return slot * lanes + lane;
    endfunction

endpackage

// File: rtl/phy_tx_multilane_ser.sv
// Per-lane frame serializer: parallel load of one FRAME_BITS-wide frame,
// then shifts left one bit per clock; the MSB is the lane's serial bit.
// Ports:
//   clk_32f  in   bit clock
//   reset    in   synchronous active-high reset (line driven low)
//   i_load   in   load i_frame on this edge instead of shifting
//   i_frame  in   FRAME_BITS frame for this lane, first bit in MSB
//   o_bit    out  serial bit (register MSB, no combinational input path)
module phy_tx_multilane_ser #(
    parameter int FRAME_BITS = 16
) (
    input  logic                  clk_32f,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic [FRAME_BITS-1:0] i_frame,
    output logic                  o_bit
);

    logic [FRAME_BITS-1:0] r_shift;

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_shift <= '0;
        end else if (i_load) begin
            r_shift <= i_frame;
        end else begin
            r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
        end
    end

    assign o_bit = r_shift[FRAME_BITS-1];

endmodule

// File: rtl/phy_tx_multilane.sv
// Multilane PHY transmitter. Words accepted over valid/ready are parked in a
// one-entry hold register and striped byte-wise across LANES serial lanes,
// MSB-first. After reset or a sync request N_COM all-COM frames are sent;
// afterwards each frame carries the held word, or IDL when nothing is held.
// Ports:
//   clk_32f      in   bit clock, all logic on rising edge
//   reset        in   synchronous active-high reset
//   data_in      in   DATA_W word to transmit
//   valid_in     in   data_in valid (transfer on valid_in && in_ready)
//   in_ready     out  hold register empty and not in reset
//   sync_req     in   request a new COM sequence (latched)
//   serial_out   out  one serial bit per lane
//   frame_start  out  first bit of a frame is on serial_out
//   tx_active    out  frames currently loaded are ACTIVE (not sync) frames
module phy_tx_multilane
    import phy_tx_multilane_pkg::*;
#(
    parameter int         DATA_W = 32,
    parameter int         LANES  = 2,
    parameter int         N_COM  = 4,
    parameter logic [7:0] COM    = COM_SYM,
    parameter logic [7:0] IDL    = IDL_SYM
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              in_ready,
    input  logic              sync_req,
    output logic [LANES-1:0]  serial_out,
    output logic              frame_start,
    output logic              tx_active
);

    localparam int FRAME_BITS = DATA_W / LANES;
    localparam int SLOTS      = FRAME_BITS / 8;
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam int CW         = $clog2(N_COM + 1);

    logic [CNT_W-1:0]  r_cnt;
    state_t            r_state;
    logic [CW-1:0]     r_com_cnt;
    logic              r_hold_full;
    logic [DATA_W-1:0] r_hold;
    logic              r_sync_latch;
    logic              r_frame_start;
    logic              r_tx_active;

    logic              w_boundary;
    logic              w_sync_done;
    logic              w_accept;
    frame_sel_t        w_sel;
    logic [FRAME_BITS-1:0] w_lane_frame [LANES];

    assign w_boundary  = (r_cnt == CNT_W'(FRAME_BITS - 1));
    // A SYNC sequence is complete once N_COM COM frames have been loaded;
    // the frame after that is decided by the ACTIVE rules.
    assign w_sync_done = (r_state == ST_ACTIVE) || (r_com_cnt >= CW'(N_COM));
    assign in_ready    = ~r_hold_full & ~reset;
    assign w_accept    = valid_in & in_ready;

    always_comb begin
        w_sel = SEL_COM;
        if (w_sync_done && !r_sync_latch) begin
            w_sel = r_hold_full ? SEL_DATA : SEL_IDL;
        end
    end

    // Striping mux: slot 0 occupies the top byte of each lane frame.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_lane_frame[l] = '0;
            for (int s = 0; s < SLOTS; s++) begin
                case (w_sel)
                    SEL_DATA: w_lane_frame[l][FRAME_BITS-1-8*s -: 8] =
                                  r_hold[DATA_W-1-8*byte_index(s, l, LANES) -: 8];
                    SEL_IDL:  w_lane_frame[l][FRAME_BITS-1-8*s -: 8] = IDL;
                    default:  w_lane_frame[l][FRAME_BITS-1-8*s -: 8] = COM;
                endcase
            end
        end
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_cnt         <= CNT_W'(FRAME_BITS - 1);
            r_state       <= ST_SYNC;
            r_com_cnt     <= '0;
            r_hold_full   <= 1'b0;
            r_sync_latch  <= 1'b0;
            r_frame_start <= 1'b0;
            r_tx_active   <= 1'b0;
        end else begin
            r_cnt         <= w_boundary ? '0 : r_cnt + 1'b1;
            r_frame_start <= w_boundary;

            // A request arriving on the edge that consumes the latch is kept.
            if (w_boundary && w_sync_done && r_sync_latch) begin
                r_sync_latch <= sync_req;
            end else begin
                r_sync_latch <= r_sync_latch | sync_req;
            end

            if (w_boundary) begin
                if (!w_sync_done) begin
                    r_com_cnt <= r_com_cnt + 1'b1;
                end else if (r_sync_latch) begin
                    // This COM frame is the first of the new sequence.
                    r_state     <= ST_SYNC;
                    r_com_cnt   <= CW'(1);
                    r_tx_active <= 1'b0;
                end else begin
                    r_state     <= ST_ACTIVE;
                    r_com_cnt   <= '0;
                    r_tx_active <= 1'b1;
                    r_hold_full <= 1'b0;
                end
            end

            // Accept only happens while hold is empty, so it never races the clear.
            if (w_accept) begin
                r_hold_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_32f) begin
        if (w_accept) begin
            r_hold <= data_in;
        end
    end

    for (genvar gl = 0; gl < LANES; gl++) begin : g_lane
        phy_tx_multilane_ser #(
            .FRAME_BITS(FRAME_BITS)
        ) u_ser (
            .clk_32f (clk_32f),
            .reset   (reset),
            .i_load  (w_boundary),
            .i_frame (w_lane_frame[gl]),
            .o_bit   (serial_out[gl])
        );
    end

    assign frame_start = r_frame_start;
    assign tx_active   = r_tx_active;

endmodule
